// File: rtl/uart_tx.sv
// UART transmitter: serialises bytes as start/data/parity/stop frames, LSB first,
// timed by the shared ena oversampling tick, with a one-deep holding register.
module uart_tx #(
    parameter int unsigned SAMPLING_FACTOR = 16,
    parameter int unsigned PARITY          = 0,
    parameter int unsigned STOP_BITS       = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] data_in,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       Tx_out,
    output logic       bussy,
    output logic       frame_done
);

    localparam logic [7:0] SF_LAST    = 8'(SAMPLING_FACTOR - 1);
    localparam logic       STOP_LAST  = 1'(STOP_BITS - 1);
    localparam logic       HAS_PARITY = (PARITY != 0);
    localparam logic       ODD_PARITY = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_e;

    function automatic logic parity_bit(input logic [7:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    state_e     state_q, state_d;
    logic [7:0] tick_q, tick_d;
    logic [2:0] bit_q, bit_d;
    logic       stop_q, stop_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic       ready_q;
    logic       tx_q, tx_d;
    logic       busy_q;
    logic       done_q, done_d;
    logic       accept_s;
    logic       wrap_s;
    logic [2:0] next_bit_s;

    assign accept_s   = in_valid && ready_q;
    assign wrap_s     = (tick_q == SF_LAST);
    assign next_bit_s = bit_q + 3'd1;

    // Next-state, line value and holding-register logic.
    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        bit_d       = bit_q;
        stop_d      = stop_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        tx_d        = tx_q;
        done_d      = 1'b0;

        if (accept_s) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
        end else begin
            hold_d      = hold_q;
        end

        if (ena) begin
            tick_d = wrap_s ? 8'd0 : tick_q + 8'd1;
            case (state_q)
                S_IDLE: begin
                    tick_d = 8'd0;
                    if (hold_full_q) begin
                        state_d     = S_START;
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                        tx_d        = 1'b0;
                    end else begin
                        tx_d        = 1'b1;
                    end
                end
                S_START: begin
                    if (wrap_s) begin
                        state_d = S_DATA;
                        bit_d   = 3'd0;
                        tx_d    = shift_q[0];
                    end else begin
                        tx_d    = 1'b0;
                    end
                end
                S_DATA: begin
                    if (wrap_s && (bit_q == 3'd7)) begin
                        if (HAS_PARITY) begin
                            state_d = S_PARITY;
                            tx_d    = parity_bit(shift_q, ODD_PARITY);
                        end else begin
                            state_d = S_STOP;
                            stop_d  = 1'b0;
                            tx_d    = 1'b1;
                        end
                    end else if (wrap_s) begin
                        bit_d = next_bit_s;
                        tx_d  = shift_q[next_bit_s];
                    end else begin
                        tx_d  = shift_q[bit_q];
                    end
                end
                S_PARITY: begin
                    if (wrap_s) begin
                        state_d = S_STOP;
                        stop_d  = 1'b0;
                        tx_d    = 1'b1;
                    end else begin
                        tx_d    = tx_q;
                    end
                end
                S_STOP: begin
                    // A queued byte starts on the same edge that ends the last stop bit.
                    if (wrap_s && (stop_q == STOP_LAST)) begin
                        done_d = 1'b1;
                        if (hold_full_q) begin
                            state_d     = S_START;
                            shift_d     = hold_q;
                            hold_full_d = 1'b0;
                            tx_d        = 1'b0;
                        end else begin
                            state_d     = S_IDLE;
                            tx_d        = 1'b1;
                        end
                    end else if (wrap_s) begin
                        stop_d = stop_q + 1'b1;
                        tx_d   = 1'b1;
                    end else begin
                        tx_d   = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    tick_d  = 8'd0;
                    tx_d    = 1'b1;
                end
            endcase
        end else begin
            tick_d = tick_q;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            tick_q      <= 8'd0;
            bit_q       <= 3'd0;
            stop_q      <= 1'b0;
            shift_q     <= 8'd0;
            hold_q      <= 8'd0;
            hold_full_q <= 1'b0;
            ready_q     <= 1'b1;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            stop_q      <= stop_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            ready_q     <= !hold_full_d;
            tx_q        <= tx_d;
            busy_q      <= (state_d != S_IDLE);
            done_q      <= done_d;
        end
    end

    assign in_ready   = ready_q;
    assign Tx_out     = tx_q;
    assign bussy      = busy_q;
    assign frame_done = done_q;

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter: serialises bytes into start/data/parity/stop frames on a single line, LSB first. It runs on the same `ena` oversampling tick and `SAMPLING_FACTOR` timing base as the UART receiver, so one bit lasts exactly `SAMPLING_FACTOR` enabled cycles and `Tx_out` can drive the receiver's `Bit_in` directly. A one-deep holding register with a valid/ready handshake lets the host queue the next byte while the current frame is on the line, giving gap-free back-to-back frames.

## Interface
- `SAMPLING_FACTOR`, 16: `ena` ticks per bit; legal range 2..255.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: 1 or 2.
- `clk`  in  1  system clock. One clock; reset is synchronous and active-low.
- `rst_n`  in  1  synchronous active-low reset.
- `ena`  in  1  oversampling tick; all line timing advances only on cycles with `ena`=1.
- `data_in`  in  8  byte to send.
- `in_valid`  in  1  `data_in` valid.
- `in_ready`  out  1  holding register empty; the byte is accepted on `in_valid & in_ready`.
- `Tx_out`  out  1  serial line; idle high.
- `bussy`  out  1  frame in progress (any state but IDLE).
- `frame_done`  out  1  one-`clk` pulse at the end of the last stop bit.

## Operation
- Reset (`rst_n`=0 at posedge): `Tx_out`=1, `bussy`=0, `in_ready`=1, `frame_done`=0. State goes to IDLE, the holding register is emptied, the tick counter and bit index go to 0. A reset mid-frame aborts the frame: the line is high on the next cycle and the pending byte is discarded.
- Handshake is independent of `ena`. An accept on a posedge writes `data_in` into the holding register, and `in_ready` goes 0 from the next cycle. `in_ready` is a registered `!hold_full`. It returns to 1 the cycle after the holding register is drained into the shifter. Accept and drain never coincide, because `in_ready`=0 whenever the register is full.
- States: IDLE, START_BIT, DATA, PARITY, STOP_BIT.
  - IDLE -> START_BIT on a cycle with `ena`=1 and holding register full. On that edge: load the shifter, empty the holding register, drive `Tx_out`=0, tick counter=0.
  - Tick counter: increments on each `ena`. On an `ena` with counter==`SAMPLING_FACTOR`-1, it wraps to 0 and the bit advances.
  - START_BIT -> DATA. The data bits go out in order `data[0]`..`data[7]`, bit index 0..7.
  - DATA -> PARITY after bit 7 if `PARITY`!=0, otherwise DATA -> STOP_BIT. The parity bit is the XOR of the 8 data bits for even parity and the inverse of that XOR for odd parity.
  - PARITY -> STOP_BIT. `Tx_out`=1 for `STOP_BITS`×`SAMPLING_FACTOR` ticks.
  - End of the last stop tick: `frame_done`=1 for that cycle. If the holding register is full, go straight to START_BIT on the same edge (no idle gap). Otherwise go to IDLE.
- `Tx_out` is registered with no combinational path from the inputs. `ena`=0 freezes the state, counter and line.

## Timing
- Latency: for a byte accepted while IDLE, `Tx_out` falls on the first `ena` edge strictly after the accept cycle.
- Frame length: (1 + 8 + (PARITY?1:0) + STOP_BITS) × `SAMPLING_FACTOR` `ena` ticks, exact. Each bit holds for exactly `SAMPLING_FACTOR` ticks.
- `bussy` is 1 from the start-bit edge through the last stop tick. During back-to-back frames it stays 1 continuously.
- `frame_done` asserts on the `ena` edge that completes the last stop bit and lasts one `clk` cycle.
- Width rules: the tick counter is 8 bits, the bit index is 3 bits, and the stop-bit counter is 1 bit.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `in_valid`=1 -> `Tx_out`=1, `bussy`=0, `in_ready`=1, `frame_done`=0, and nothing is accepted.
- 8N1, SF=16, `ena` every cycle, send 0xA5 -> `Tx_out` sequence 0,1,0,1,0,0,1,0,1,1, each held 16 cycles; 160 cycles total; one `frame_done` pulse; `bussy` is 0 afterwards.
- Back-to-back: 0x00, with 0xFF queued during the frame -> the second start bit follows the first stop bit with no extra tick; `in_ready`=0 while 0xFF waits; two `frame_done` pulses 160 ticks apart.
- `ena` gating: `ena` high 1 cycle in 4, send 0x3C -> each bit spans 64 `clk` cycles; line state is unchanged while `ena`=0.
- Even parity, 0x07 -> parity bit 1; odd parity, 0x07 -> 0; `STOP_BITS`=2 -> 32 high ticks before the next start bit.
- Reset mid-frame at data bit 3, then send 0x5A -> the line goes high the next cycle; 0x5A frames correctly, and a loopback into the receiver yields `out`=0x5A.
